// File: rtl/aes_pkg.sv
// Shared AES definitions: state/byte widths, SubBytes FSM encoding and the
// pass-count helper used to size the sequential S-box engine.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    // Number of S-box passes needed to cover the 16 state bytes.
    function automatic int aes_npass(input int lanes);
        return 16 / lanes;
    endfunction

endpackage

// File: rtl/aes_subbytes_seq_if.sv
// Input and output valid/ready channels of the sequential SubBytes engine.
// The engine takes the slave view; whoever feeds and drains it is the master.
interface aes_subbytes_seq_if;
    import aes_pkg::*;

    logic [AES_STATE_W-1:0] in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [AES_STATE_W-1:0] out_data;
    logic                   out_valid;
    logic                   out_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid
    );

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid
    );

endinterface

// File: rtl/aes_sbox.sv
// FIPS-197 forward S-box as a combinational constant lookup.
// It has the same port names as the inverse S-box so the two are interchangeable.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] a,
    output logic [AES_BYTE_W-1:0] d
);

    // Element 0 is the leftmost byte, so each row reads like the printed table.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign d = SBOX[a];

endmodule

// File: rtl/aes_subbytes_seq.sv
// Sequential forward SubBytes: substitutes LANES bytes per cycle in place,
// MSB-first, then presents the whole 128-bit result until it is taken.
module aes_subbytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    aes_subbytes_seq_if.slave  bus
);

    localparam int NPASS = aes_npass(LANES);
    localparam int PW    = (NPASS > 1) ? $clog2(NPASS) : 1;
    localparam int LW    = LANES * AES_BYTE_W;
    localparam logic [PW-1:0] LAST_PASS = PW'(NPASS - 1);

    aes_state_e             state_q, state_d;
    logic [PW-1:0]          pass_q, pass_d;
    logic [AES_STATE_W-1:0] work_q, work_d;
    logic [AES_STATE_W-1:0] out_data_q, out_data_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;

    logic [6:0]             sel_lsb;
    logic [LW-1:0]          lane_in;
    logic [LW-1:0]          lane_out;

    // Pass 0 covers the most significant bytes, so the slice walks downwards.
    always_comb begin
        sel_lsb = 7'((NPASS - 1 - int'(pass_q)) * LW);
    end

    assign lane_in = work_q[sel_lsb +: LW];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            aes_sbox u_sbox (
                .a (lane_in [LW-1-gi*AES_BYTE_W -: AES_BYTE_W]),
                .d (lane_out[LW-1-gi*AES_BYTE_W -: AES_BYTE_W])
            );
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        work_d      = work_q;
        out_data_d  = out_data_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    work_d     = bus.in_data;
                    pass_d     = '0;
                    in_ready_d = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                work_d[sel_lsb +: LW] = lane_out;
                if (pass_q == LAST_PASS) begin
                    out_data_d  = work_d;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    pass_d = pass_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pass_q      <= '0;
            work_q      <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pass_q      <= pass_d;
            work_q      <= work_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// Bench for aes_subbytes_seq: three instances (LANES = 1, 4, 16) exercised with
// directed vectors, backpressure, mid-operation reset and random streaming.
module tb_aes_subbytes_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid_a [3];
    logic         out_ready_a[3];
    logic [127:0] in_data_a  [3];
    wire          in_ready_w [3];
    wire          out_valid_w[3];
    wire  [127:0] out_data_w [3];

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_tab [256];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int L = (gi == 0) ? 1 : ((gi == 1) ? 4 : 16);
        aes_subbytes_seq_if bus ();
        assign bus.in_data      = in_data_a[gi];
        assign bus.in_valid     = in_valid_a[gi];
        assign bus.out_ready    = out_ready_a[gi];
        assign in_ready_w[gi]   = bus.in_ready;
        assign out_valid_w[gi]  = bus.out_valid;
        assign out_data_w[gi]   = bus.out_data;
        aes_subbytes_seq #(.LANES(L)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    // Reference S-box from GF(2^8) inversion plus the affine transform.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] b);
        logic [7:0] inv = 8'h00;
        if (b != 8'h00) begin
            for (int c = 1; c < 256; c++) begin
                if (gmul(b, 8'(c)) == 8'h01) inv = 8'(c);
            end
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_model(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = ref_tab[s[i*8 +: 8]];
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    typedef struct {
        int           k;
        logic [127:0] din;
        logic [127:0] exp;
        int           lat;
        string        tag;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input int k, input logic [127:0] din, input logic [127:0] exp,
                           input int lat, input string tag);
        int n;
        bit rdy_bad;
        @(negedge clk);
        check({tag, "_idle_ready"}, 128'(in_ready_w[k]), 128'd1);
        in_data_a[k]   = din;
        in_valid_a[k]  = 1'b1;
        out_ready_a[k] = 1'b0;
        @(negedge clk);
        in_valid_a[k] = 1'b0;
        in_data_a[k]  = '0;
        n = 0;
        rdy_bad = 1'b0;
        while (!out_valid_w[k] && n < 40) begin
            if (in_ready_w[k]) rdy_bad = 1'b1;
            @(negedge clk);
            n++;
        end
        if (in_ready_w[k]) rdy_bad = 1'b1;
        check({tag, "_latency"}, 128'(n), 128'(lat));
        check({tag, "_busy_ready_low"}, 128'(rdy_bad), 128'd0);
        check({tag, "_data"}, out_data_w[k], exp);
        out_ready_a[k] = 1'b1;
        @(negedge clk);
        out_ready_a[k] = 1'b0;
        check({tag, "_valid_cleared"}, 128'(out_valid_w[k]), 128'd0);
        check({tag, "_ready_back"}, 128'(in_ready_w[k]), 128'd1);
        $display("vector %s lanes_idx=%0d in=%h out=%h cycles=%0d", tag, k, din, out_data_w[k], n);
    endtask

    task automatic stream(input int k);
        logic [127:0] expq[$];
        logic [127:0] pd, pod;
        int sent, got, cyc;
        bit piv, pir, pov, por;
        sent = 0; got = 0; cyc = 0;
        piv = 0; pir = 0; pov = 0; por = 0;
        pd = '0; pod = '0;
        while (got < 100 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (piv && pir) begin
                expq.push_back(sub_model(pd));
                sent++;
            end
            if (pov && por) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stream_extra_output actual=%h required=none", pod);
                end else begin
                    check($sformatf("stream_k%0d_item%0d", k, got), pod, expq.pop_front());
                end
                got++;
            end
            pir = in_ready_w[k];
            pov = out_valid_w[k];
            pod = out_data_w[k];
            piv = (sent < 100) && ($urandom_range(0, 1) == 1);
            pd  = {$urandom, $urandom, $urandom, $urandom};
            por = ($urandom_range(0, 1) == 1);
            in_valid_a[k]  = piv;
            in_data_a[k]   = pd;
            out_ready_a[k] = por;
        end
        in_valid_a[k]  = 1'b0;
        out_ready_a[k] = 1'b0;
        check($sformatf("stream_k%0d_count", k), 128'(got), 128'd100);
        check($sformatf("stream_k%0d_leftover", k), 128'(expq.size()), 128'd0);
        $display("stream lanes_idx=%0d sent=%0d received=%0d cycles=%0d", k, sent, got, cyc);
    endtask

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    initial begin
        bit bad;
        int n;
        for (int i = 0; i < 256; i++) ref_tab[i] = sbox_calc(8'(i));
        for (int k = 0; k < 3; k++) begin
            in_valid_a[k]  = 1'b0;
            out_ready_a[k] = 1'b0;
            in_data_a[k]   = '0;
        end

        vecs[0] = '{1, 128'h0053FF01000000000000000000000000,
                       128'h63ED167C636363636363636363636363, 4, "spot_l4"};
        vecs[1] = '{0, FIPS_IN, FIPS_OUT, 16, "fips_l1"};
        vecs[2] = '{1, FIPS_IN, FIPS_OUT, 4, "fips_l4"};
        vecs[3] = '{2, FIPS_IN, FIPS_OUT, 1, "fips_l16"};
        vecs[4] = '{2, 128'h0, {16{8'h63}}, 1, "zero_l16"};
        vecs[5] = '{0, {16{8'hFF}}, {16{8'h16}}, 16, "ones_l1"};
        vecs[6] = '{2, 128'h0053FF01000000000000000000000000,
                       128'h63ED167C636363636363636363636363, 1, "spot_l16"};

        // Reset values while rst_n is held low.
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_in_ready_k%0d", k), 128'(in_ready_w[k]), 128'd1);
            check($sformatf("reset_out_valid_k%0d", k), 128'(out_valid_w[k]), 128'd0);
            check($sformatf("reset_out_data_k%0d", k), out_data_w[k], 128'h0);
        end
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++)
            run_vec(vecs[v].k, vecs[v].din, vecs[v].exp, vecs[v].lat, vecs[v].tag);

        // Backpressure on the LANES=4 instance.
        @(negedge clk);
        in_data_a[1]  = FIPS_IN;
        in_valid_a[1] = 1'b1;
        @(negedge clk);
        in_valid_a[1] = 1'b0;
        n = 0;
        while (!out_valid_w[1] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", 128'(out_valid_w[1]), 128'd1);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid_w[1] !== 1'b1 || in_ready_w[1] !== 1'b0 || out_data_w[1] !== FIPS_OUT)
                bad = 1'b1;
            if (i == 2) begin
                in_data_a[1]  = {16{8'hA5}};
                in_valid_a[1] = 1'b1;
            end
            @(negedge clk);
        end
        check("bp_hold_stable", 128'(bad), 128'd0);
        check("bp_hold_data", out_data_w[1], FIPS_OUT);
        in_valid_a[1]  = 1'b0;
        out_ready_a[1] = 1'b1;
        @(negedge clk);
        out_ready_a[1] = 1'b0;
        check("bp_release_valid", 128'(out_valid_w[1]), 128'd0);
        check("bp_release_ready", 128'(in_ready_w[1]), 128'd1);
        check("bp_release_data_kept", out_data_w[1], FIPS_OUT);
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid_w[1] !== 1'b0) bad = 1'b1;
        end
        check("bp_ignored_input_dropped", 128'(bad), 128'd0);
        $display("backpressure lanes_idx=1 out=%h", out_data_w[1]);

        // Asynchronous reset in BUSY at pass 2 on the LANES=4 instance.
        @(negedge clk);
        in_data_a[1]  = FIPS_IN;
        in_valid_a[1] = 1'b1;
        @(negedge clk);
        in_valid_a[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy_ready_low", 128'(in_ready_w[1]), 128'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_ready", 128'(in_ready_w[1]), 128'd1);
        check("rst_async_valid", 128'(out_valid_w[1]), 128'd0);
        check("rst_async_data", out_data_w[1], 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid_w[1] !== 1'b0) bad = 1'b1;
        end
        check("rst_no_output_after", 128'(bad), 128'd0);
        $display("midreset lanes_idx=1 in_ready=%0b out_valid=%0b", in_ready_w[1], out_valid_w[1]);

        for (int k = 0; k < 3; k++) stream(k);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_subbytes_seq.md
Name: aes_subbytes_seq

Overview:
Sequential forward SubBytes engine for the AES encryption datapath. It is the encrypt-side counterpart of the decryption inverse-SubBytes stage. It accepts a 128-bit state over a valid/ready handshake and substitutes LANES bytes per cycle through shared forward S-boxes. It returns the 128-bit result over a second valid/ready handshake, trading latency for S-box area in the iterative encryption core.

Parameters:
LANES, 4, S-box instances used in parallel; legal values 1, 2, 4, 8, 16; the number of passes is NPASS = 16/LANES.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  128  state to substitute; byte 0 = in_data[127:120]
in_valid  input  1  in_data is valid
in_ready  output  1  engine can accept a state
out_data  output  128  substituted state, same byte ordering as in_data
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts out_data

Behaviour:
- Reset is asynchronous and active-low. One clock, clk; no other clock domains.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=128'h0, pass counter=0, working register=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch in_data into the working register, clear the pass counter, and go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle, the LANES bytes at pass index p (bytes p*LANES .. p*LANES+LANES-1, MSB-first) go through the S-boxes. Results are written back in place.
  - p increments each cycle. After pass NPASS-1, go to DONE and load out_data.
  - in_valid is ignored while in BUSY.
- DONE:
  - out_valid=1 and out_data is held stable.
  - On out_ready, clear out_valid and go to IDLE.
  - out_data retains its last value after the handshake; it does not need to be cleared.
- Latency: accept at edge T gives out_valid=1 after edge T+NPASS. For LANES=4 this is 4 cycles; for LANES=16 it is 1 cycle.
- Throughput: one state per NPASS+2 cycles with out_ready tied high. Back-to-back acceptance in DONE is not supported.
- out_ready held low: stays in DONE indefinitely with out_data stable; in_ready stays 0.
- out_ready high before out_valid: no effect.
- Pass counter width is $clog2(NPASS), minimum 1 bit. The final pass is detected by compare with NPASS-1, not by wrap-around.
- rst_n asserted mid-BUSY or in DONE: immediate return to reset values. The partial state is discarded; no output is produced.
- S-box mapping is the FIPS-197 forward S-box and is purely combinational inside the pass.
- No X propagation: unused working-register bytes are never driven from uninitialised sources.

Decomposition:
- Shared package aes_pkg holds:
  - the FSM state encoding (IDLE/BUSY/DONE)
  - the constants AES_STATE_W=128 and AES_BYTE_W=8
  - a function for the pass count 16/LANES
- Sub-module aes_sbox (ports a[7:0] in, d[7:0] out) is the forward S-box ROM, instantiated LANES times via generate. It mirrors aes_inv_sbox and keeps the same port names.

Test Plan:
- Single S-box spot check, LANES=4:
  - Stimulus: in_data=128'h00_53_FF_01_000000000000000000000000.
  - Required: out_data=128'h63_ED_16_7C_636363636363636363636363 after exactly 4 cycles; in_ready=0 throughout.
- FIPS-197 App. B round 1:
  - Stimulus: in_data=193de3bea0f4e22b9ac68d2ae9f84808.
  - Required: out_data=d42711aee0bf98f1b8b45de51e415230 for LANES=1, 4 and 16. Latency must be 16, 4 and 1 cycles respectively.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid rises.
  - Required: out_data stable; out_valid=1; in_ready=0; a new in_valid is ignored. Then out_ready=1 for 1 cycle gives out_valid=0 and in_ready=1 on the next cycle.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 in BUSY at pass 2 (LANES=4), async between edges.
  - Required: out_valid=0 and in_ready=1 immediately. No out_valid appears afterwards until a new accept.
- Streaming:
  - Stimulus: 100 random states with in_valid and out_ready randomly toggled.
  - Required: every output equals the reference-model SubBytes of the corresponding input, in order, with no drops or duplicates.
